mc_control_fsm: RTL and testbench

// Parametrised multicycle control unit for the RV32I-subset core. Sequences FETCH/DECODE/execute

---
 rtl/mc_ctrl_pkg.sv | 33 +++
 rtl/mc_control_fsm.sv | 133 +++++++++++++
 tb/tb_mc_control_fsm.sv | 110 +++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding, opcodes and datapath select codes for the multicycle control FSM
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_JAL, S_JALR, S_BEQ, S_LUI, S_AUIPC, S_TRAP
  } state_t;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [1:0] SA_PC = 2'd0, SA_OLDPC = 2'd1, SA_RS1 = 2'd2;
  localparam logic [1:0] SB_RS2 = 2'd0, SB_IMM = 2'd1, SB_FOUR = 2'd2;
  localparam logic [1:0] RS_ALUOUT = 2'd0, RS_MEM = 2'd1, RS_ALU = 2'd2;
  localparam logic [1:0] AO_ADD = 2'd0, AO_SUB = 2'd1, AO_FUNCT = 2'd2;
  function automatic state_t dispatch(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE: return S_MEMADR;
      OPC_RTYPE:           return S_EXECR;
      OPC_ITYPE:           return S_EXECI;
      OPC_JAL:             return S_JAL;
      OPC_JALR:            return S_JALR;
      OPC_BEQ:             return S_BEQ;
      OPC_LUI:             return S_LUI;
      OPC_AUIPC:           return S_AUIPC;
      default:             return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I-subset control unit with memory wait timeout and illegal-opcode trap
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W       = 7,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] i_opc,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  input  logic             i_trap_clr,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_adr_src,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_reg_we,
  output logic [1:0]       o_src_a,
  output logic [1:0]       o_src_b,
  output logic [1:0]       o_res_src,
  output logic [1:0]       o_alu_op,
  output logic             o_instr_done,
  output logic             o_trap
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_opc;
  logic             w_wait, w_tmo;
  assign w_opc  = 7'(i_opc);
  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_tmo  = w_wait && !i_mem_ready && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // Counter only runs while lingering in a memory wait state; any state change clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_wait && w_next == r_state) ? r_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = i_mem_ready ? S_DECODE : w_tmo ? S_TRAP : S_FETCH;
      S_DECODE: w_next = dispatch(w_opc);
      S_MEMADR: w_next = (w_opc == OPC_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = i_mem_ready ? S_MEMWB : w_tmo ? S_TRAP : S_MEMRD;
      S_MEMWR:  w_next = i_mem_ready ? S_FETCH : w_tmo ? S_TRAP : S_MEMWR;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: w_next = S_ALUWB;
      S_JALR:   w_next = S_JAL;
      S_TRAP:   w_next = i_trap_clr ? S_FETCH : S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_reg_we     = 1'b0;
    o_src_a      = SA_PC;
    o_src_b      = SB_RS2;
    o_res_src    = RS_ALUOUT;
    o_alu_op     = AO_ADD;
    o_instr_done = 1'b0;
    o_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        o_ir_we   = i_mem_ready;
        o_pc_we   = i_mem_ready;
        o_src_b   = SB_FOUR;
        o_res_src = RS_ALU;
      end
      S_DECODE, S_AUIPC: begin
        o_src_a = SA_OLDPC;
        o_src_b = SB_IMM;
      end
      S_MEMADR, S_JALR, S_LUI: begin
        o_src_a = SA_RS1;
        o_src_b = SB_IMM;
      end
      S_MEMRD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_res_src    = RS_MEM;
        o_reg_we     = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_mem_req    = 1'b1;
        o_mem_we     = 1'b1;
        o_adr_src    = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_EXECR: begin
        o_src_a  = SA_RS1;
        o_alu_op = AO_FUNCT;
      end
      S_EXECI: begin
        o_src_a  = SA_RS1;
        o_src_b  = SB_IMM;
        o_alu_op = AO_FUNCT;
      end
      S_ALUWB: begin
        o_reg_we     = 1'b1;
        o_instr_done = 1'b1;
      end
      S_JAL: begin
        o_src_a      = SA_OLDPC;
        o_src_b      = SB_FOUR;
        o_pc_we      = 1'b1;
        o_reg_we     = 1'b1;
        o_instr_done = 1'b1;
      end
      S_BEQ: begin
        o_src_a      = SA_RS1;
        o_alu_op     = AO_SUB;
        o_pc_we      = i_zero;
        o_instr_done = 1'b1;
      end
      S_TRAP:  o_trap = 1'b1;
      default: o_trap = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: vector table plus hand sequences, outputs checked through an expectation queue
module tb_mc_control_fsm;
  logic       clk = 1'b0, rst = 1'b1, i_zero = 1'b0, i_mem_ready = 1'b0, i_trap_clr = 1'b0;
  logic [6:0] i_opc = '0;
  logic       o_mem_req, o_mem_we, o_adr_src, o_ir_we, o_pc_we, o_reg_we, o_instr_done, o_trap;
  logic [1:0] o_src_a, o_src_b, o_res_src, o_alu_op;
  logic [15:0] w_out;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mc_control_fsm #(.OPC_W(7), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .i_opc(i_opc), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .i_trap_clr(i_trap_clr), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_adr_src(o_adr_src),
    .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_reg_we(o_reg_we), .o_src_a(o_src_a),
    .o_src_b(o_src_b), .o_res_src(o_res_src), .o_alu_op(o_alu_op),
    .o_instr_done(o_instr_done), .o_trap(o_trap)
  );
  assign w_out = {o_mem_req, o_mem_we, o_adr_src, o_ir_we, o_pc_we, o_reg_we,
                  o_src_a, o_src_b, o_res_src, o_alu_op, o_instr_done, o_trap};
  // {req,we,adr,ir,pc,reg, src_a,src_b,res_src,alu_op, done,trap}
  localparam logic [15:0] E_FETCH_R = {6'b100110, 2'd0, 2'd2, 2'd2, 2'd0, 2'b00};
  localparam logic [15:0] E_FETCH_W = {6'b100000, 2'd0, 2'd2, 2'd2, 2'd0, 2'b00};
  localparam logic [15:0] E_DECODE  = {6'b000000, 2'd1, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [15:0] E_MEMADR  = {6'b000000, 2'd2, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [15:0] E_MEMRD   = {6'b101000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [15:0] E_MEMWB   = {6'b000001, 2'd0, 2'd0, 2'd1, 2'd0, 2'b10};
  localparam logic [15:0] E_MEMWR_W = {6'b111000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [15:0] E_MEMWR_R = {6'b111000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b10};
  localparam logic [15:0] E_EXECR   = {6'b000000, 2'd2, 2'd0, 2'd0, 2'd2, 2'b00};
  localparam logic [15:0] E_EXECI   = {6'b000000, 2'd2, 2'd1, 2'd0, 2'd2, 2'b00};
  localparam logic [15:0] E_ALUWB   = {6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'b10};
  localparam logic [15:0] E_JAL     = {6'b000011, 2'd1, 2'd2, 2'd0, 2'd0, 2'b10};
  localparam logic [15:0] E_BEQ1    = {6'b000010, 2'd2, 2'd0, 2'd0, 2'd1, 2'b10};
  localparam logic [15:0] E_BEQ0    = {6'b000000, 2'd2, 2'd0, 2'd0, 2'd1, 2'b10};
  localparam logic [15:0] E_TRAP    = {6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b01};
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011, ADDI = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BEQ = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, ILL = 7'b1111111;
  typedef struct {
    logic r; logic [6:0] op; logic z; logic rd; logic cl; logic ck; logic [15:0] ex;
  } vec_t;
  vec_t tbl[$];
  logic [15:0] sb[$];
  function automatic void add(input logic r, input logic [6:0] op, input logic z, input logic rd,
                              input logic cl, input logic ck, input logic [15:0] ex);
    tbl.push_back('{r: r, op: op, z: z, rd: rd, cl: cl, ck: ck, ex: ex});
  endfunction
  function automatic void fd(input logic [6:0] op);
    add(0, op, 0, 1, 0, 1, E_FETCH_R);
    add(0, op, 0, 1, 0, 1, E_DECODE);
  endfunction
  task automatic step(input logic r, input logic [6:0] op, input logic z, input logic rd,
                      input logic cl, input logic ck, input logic [15:0] ex, input string nm);
    logic [15:0] e;
    @(negedge clk);
    rst = r; i_opc = op; i_zero = z; i_mem_ready = rd; i_trap_clr = cl;
    if (ck) sb.push_back(ex);
    #2;
    if (ck) begin
      e = sb.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, w_out, e);
      end
    end
  endtask
  initial begin
    add(1, ADDI, 0, 0, 0, 0, E_FETCH_W);
    add(0, ADDI, 0, 0, 0, 1, E_FETCH_W);
    add(1, ADDI, 0, 0, 0, 1, E_FETCH_W);
    fd(ADDI); add(0, ADDI, 0, 1, 0, 1, E_EXECI); add(0, ADDI, 0, 1, 0, 1, E_ALUWB);
    fd(ADD);  add(0, ADD, 0, 1, 0, 1, E_EXECR);  add(0, ADD, 0, 1, 0, 1, E_ALUWB);
    fd(LW);   add(0, LW, 0, 1, 0, 1, E_MEMADR);
    for (int i = 0; i < 3; i++) add(0, LW, 0, 0, 0, 1, E_MEMRD);
    add(0, LW, 0, 1, 0, 1, E_MEMRD); add(0, LW, 0, 1, 0, 1, E_MEMWB);
    fd(SW);   add(0, SW, 0, 1, 0, 1, E_MEMADR);
    add(0, SW, 0, 0, 0, 1, E_MEMWR_W); add(0, SW, 0, 1, 0, 1, E_MEMWR_R);
    fd(BEQ);  add(0, BEQ, 1, 1, 0, 1, E_BEQ1);
    fd(BEQ);  add(0, BEQ, 0, 1, 0, 1, E_BEQ0);
    fd(JAL);  add(0, JAL, 0, 1, 0, 1, E_JAL);
    fd(JALR); add(0, JALR, 0, 1, 0, 1, E_MEMADR); add(0, JALR, 0, 1, 0, 1, E_JAL);
    fd(LUI);  add(0, LUI, 0, 1, 0, 1, E_MEMADR);  add(0, LUI, 0, 1, 0, 1, E_ALUWB);
    fd(AUIPC); add(0, AUIPC, 0, 1, 0, 1, E_DECODE); add(0, AUIPC, 0, 1, 0, 1, E_ALUWB);
    fd(ILL);
    add(0, ILL, 0, 1, 0, 1, E_TRAP); add(0, ILL, 0, 1, 0, 1, E_TRAP);
    add(0, ILL, 0, 1, 1, 1, E_TRAP); add(0, ILL, 0, 0, 0, 1, E_FETCH_W);
    foreach (tbl[i])
      step(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].rd, tbl[i].cl, tbl[i].ck, tbl[i].ex,
           $sformatf("vec%0d", i));
    // reset while a store waits on memory, then FETCH must time out after exactly 16 cycles
    step(0, SW, 0, 1, 0, 1, E_FETCH_R, "rst_fetch");
    step(0, SW, 0, 1, 0, 1, E_DECODE, "rst_decode");
    step(0, SW, 0, 1, 0, 1, E_MEMADR, "rst_memadr");
    step(0, SW, 0, 0, 0, 1, E_MEMWR_W, "rst_memwr_wait");
    step(1, SW, 0, 0, 0, 1, E_MEMWR_W, "rst_in_memwr");
    for (int i = 0; i < 16; i++) step(0, SW, 0, 0, 0, 1, E_FETCH_W, $sformatf("tmo_fetch%0d", i));
    step(0, SW, 0, 0, 0, 1, E_TRAP, "tmo_trap");
    step(0, SW, 0, 0, 1, 1, E_TRAP, "tmo_clr");
    // ready arriving on the final permitted MEMRD cycle must win over the timeout
    step(0, LW, 0, 1, 0, 1, E_FETCH_R, "edge_fetch");
    step(0, LW, 0, 1, 0, 1, E_DECODE, "edge_decode");
    step(0, LW, 0, 1, 0, 1, E_MEMADR, "edge_memadr");
    for (int i = 0; i < 15; i++) step(0, LW, 0, 0, 0, 1, E_MEMRD, $sformatf("edge_memrd%0d", i));
    step(0, LW, 0, 1, 0, 1, E_MEMRD, "edge_memrd_ready");
    step(0, LW, 0, 1, 0, 1, E_MEMWB, "edge_memwb");
    step(0, LW, 0, 1, 0, 1, E_FETCH_R, "edge_back_fetch");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
